adc_scan: RTL and testbench



---
 rtl/adc_scan_pkg.sv | 24 ++
 rtl/spi_byte_xfer.sv | 74 +++++++
 rtl/adc_scan.sv | 207 ++++++++++++++++++++
 tb/tb_adc_scan.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the MCP3008-class scanning front end.
package adc_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_LOW,
    BYTE0,
    BYTE1,
    BYTE2,
    STORE,
    CS_HIGH
  } state_t;

  localparam logic [7:0] START_BYTE = 8'h01;
  localparam logic [7:0] DUMMY_BYTE = 8'h00;
  localparam int SAMPLE_W = 10;
  localparam int CH_W     = 3;

  // Second command byte: SGL/DIFF flag, channel select, then don't-care bits.
  function automatic logic [7:0] byte1_cmd(input logic diff, input logic [CH_W-1:0] ch);
    return {~diff, ch, 4'b0000};
  endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// One MSB-first 8-bit SPI mode-0 exchange; sclk is high for the first half of each bit.
module spi_byte_xfer #(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx,
  output logic [7:0] rx,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic             active_reg;
  logic [DIV_W-1:0] div_reg;
  logic [3:0]       half_reg;
  logic [6:0]       tx_sh_reg;
  logic [7:0]       rx_sh_reg;
  logic             sclk_reg;
  logic             mosi_reg;
  logic             div_last;

  assign div_last = (div_reg == DIV_W'(CLK_DIV - 1));
  assign done     = active_reg && div_last && (half_reg == 4'd15);
  assign rx       = rx_sh_reg;
  assign sclk     = sclk_reg;
  assign mosi     = mosi_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_reg <= 1'b0;
      div_reg    <= '0;
      half_reg   <= '0;
      tx_sh_reg  <= '0;
      rx_sh_reg  <= '0;
      sclk_reg   <= 1'b0;
      mosi_reg   <= 1'b0;
    end else begin
      // miso is taken during the first clk cycle of each sclk high phase
      if (active_reg && sclk_reg && (div_reg == '0))
        rx_sh_reg <= {rx_sh_reg[6:0], miso};

      if (start && (!active_reg || done)) begin
        active_reg <= 1'b1;
        div_reg    <= '0;
        half_reg   <= '0;
        sclk_reg   <= 1'b1;
        mosi_reg   <= tx[7];
        tx_sh_reg  <= tx[6:0];
      end else if (active_reg) begin
        if (div_last) begin
          div_reg  <= '0;
          half_reg <= half_reg + 4'd1;
          if (!half_reg[0]) begin
            sclk_reg  <= 1'b0;
            mosi_reg  <= tx_sh_reg[6];
            tx_sh_reg <= {tx_sh_reg[5:0], 1'b0};
          end else if (half_reg == 4'd15) begin
            active_reg <= 1'b0;
          end else begin
            sclk_reg <= 1'b1;
          end
        end else begin
          div_reg <= div_reg + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/adc_scan.sv
// Multi-channel MCP3008 scanner with valid/ready sample output.
// Optional auto-trigger timer enabled by defining ADC_SCAN_TIMER_EN.
module adc_scan
  import adc_scan_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int CLK_DIV = 8,
  parameter int CS_IDLE = 4,
  parameter int PERIOD  = 48000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_scan,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic                diff_mode,
  output logic                spi_clk,
  output logic                spi_mosi,
  output logic                spi_cs,
  input  logic                spi_miso,
  output logic                busy,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [SAMPLE_W-1:0] sample,
  output logic [CH_W-1:0]     sample_ch,
  output logic                scan_done
);

  localparam int TIMER_W = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

  state_t              state_reg;
  logic [7:0]          mask_reg;
  logic                diff_reg;
  logic [CH_W-1:0]     ch_reg;
  logic [1:0]          hi_reg;
  logic [7:0]          lo_reg;
  logic [TIMER_W-1:0]  timer_reg;
  logic                spi_cs_reg;
  logic                sample_valid_reg;
  logic [SAMPLE_W-1:0] sample_reg;
  logic [CH_W-1:0]     sample_ch_reg;
  logic                scan_done_reg;

  logic [7:0] mask_ext;
  logic [7:0] above;
  logic [3:0] first_sel;
  logic [3:0] next_sel;
  logic       trigger;
  logic       load;
  logic       xfer_start;
  logic [7:0] xfer_tx;
  logic [7:0] xfer_rx;
  logic       xfer_done;

  // {found, index} of the lowest set bit
  function automatic logic [3:0] first_set(input logic [7:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) r = {1'b1, 3'(i)};
    return r;
  endfunction

  for (genvar gi = 0; gi < 8; gi++) begin : g_mask
    if (gi < NUM_CH) begin : g_used
      assign mask_ext[gi] = ch_mask[gi];
    end else begin : g_pad
      assign mask_ext[gi] = 1'b0;
    end
    assign above[gi] = mask_reg[gi] && (3'(gi) > ch_reg);
  end

  assign first_sel = first_set(mask_ext);
  assign next_sel  = first_set(above);

`ifdef ADC_SCAN_TIMER_EN
  localparam int TICK_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  logic [TICK_W-1:0] tick_reg;
  logic              tick;

  assign tick    = (tick_reg == TICK_W'(PERIOD - 1));
  assign trigger = start_scan | tick;

  always_ff @(posedge clk) begin
    if (rst)       tick_reg <= '0;
    else if (tick) tick_reg <= '0;
    else           tick_reg <= tick_reg + TICK_W'(1);
  end
`else
  assign trigger = start_scan;
`endif

  assign load = (state_reg == STORE) && (!sample_valid_reg || sample_ready);

  always_comb begin
    xfer_start = 1'b0;
    xfer_tx    = DUMMY_BYTE;
    case (state_reg)
      CS_LOW: begin
        xfer_start = 1'b1;
        xfer_tx    = START_BYTE;
      end
      BYTE0: begin
        xfer_start = xfer_done;
        xfer_tx    = byte1_cmd(diff_reg, ch_reg);
      end
      BYTE1:   xfer_start = xfer_done;
      default: ;
    endcase
  end

  spi_byte_xfer #(.CLK_DIV(CLK_DIV)) u_xfer (
    .clk   (clk),
    .rst   (rst),
    .start (xfer_start),
    .tx    (xfer_tx),
    .rx    (xfer_rx),
    .done  (xfer_done),
    .sclk  (spi_clk),
    .mosi  (spi_mosi),
    .miso  (spi_miso)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      mask_reg         <= '0;
      diff_reg         <= 1'b0;
      ch_reg           <= '0;
      hi_reg           <= '0;
      lo_reg           <= '0;
      timer_reg        <= '0;
      spi_cs_reg       <= 1'b1;
      sample_valid_reg <= 1'b0;
      sample_reg       <= '0;
      sample_ch_reg    <= '0;
      scan_done_reg    <= 1'b0;
    end else begin
      scan_done_reg <= 1'b0;
      if (sample_valid_reg && sample_ready)
        sample_valid_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (trigger) begin
            mask_reg <= mask_ext;
            diff_reg <= diff_mode;
            if (first_sel[3]) begin
              ch_reg     <= first_sel[2:0];
              spi_cs_reg <= 1'b0;
              state_reg  <= CS_LOW;
            end else begin
              scan_done_reg <= 1'b1;
            end
          end
        end
        CS_LOW: state_reg <= BYTE0;
        BYTE0:  if (xfer_done) state_reg <= BYTE1;
        BYTE1: begin
          if (xfer_done) begin
            hi_reg    <= xfer_rx[1:0];
            state_reg <= BYTE2;
          end
        end
        BYTE2: begin
          if (xfer_done) begin
            lo_reg    <= xfer_rx;
            state_reg <= STORE;
          end
        end
        STORE: begin
          // Holding here keeps the frame open until the consumer drains the last result
          if (load) begin
            sample_reg       <= {hi_reg, lo_reg};
            sample_ch_reg    <= ch_reg;
            sample_valid_reg <= 1'b1;
            spi_cs_reg       <= 1'b1;
            timer_reg        <= '0;
            state_reg        <= CS_HIGH;
          end
        end
        CS_HIGH: begin
          if (timer_reg == TIMER_W'(CS_IDLE - 1)) begin
            if (next_sel[3]) begin
              ch_reg     <= next_sel[2:0];
              spi_cs_reg <= 1'b0;
              state_reg  <= CS_LOW;
            end else begin
              scan_done_reg <= 1'b1;
              state_reg     <= IDLE;
            end
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy         = (state_reg != IDLE);
  assign spi_cs       = spi_cs_reg;
  assign sample_valid = sample_valid_reg;
  assign sample       = sample_reg;
  assign sample_ch    = sample_ch_reg;
  assign scan_done    = scan_done_reg;

endmodule

// File: tb/tb_adc_scan.sv
// Directed bench for adc_scan with a behavioural MCP3008 slave model.
module tb_adc_scan;

  localparam int NUM_CH  = 8;
  localparam int CLK_DIV = 8;
  localparam int CS_IDLE = 4;
  localparam int PERIOD  = 1000;
  localparam int FRAME   = 390;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_scan = 1'b0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic              diff_mode = 1'b0;
  logic              spi_clk, spi_mosi, spi_cs;
  logic              spi_miso = 1'b0;
  logic              busy, sample_valid, scan_done;
  logic              sample_ready = 1'b1;
  logic [9:0]        sample;
  logic [2:0]        sample_ch;

  adc_scan #(
    .NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE), .PERIOD(PERIOD)
  ) dut (
    .clk(clk), .rst(rst), .start_scan(start_scan), .ch_mask(ch_mask),
    .diff_mode(diff_mode), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_cs(spi_cs), .spi_miso(spi_miso), .busy(busy),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample(sample), .sample_ch(sample_ch), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  logic [9:0] adc_val [0:7] = '{10'h155, 10'h0F0, 10'h2AA, 10'h001,
                                10'h3FF, 10'h200, 10'h0AB, 10'h312};

  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          done0 = 0;
  logic [12:0] sq[$];
  logic [23:0] frame_q[$];
  int          cs_fall_q[$];
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  int          bit_cnt = 0;
  logic [23:0] fbits = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave response: leading filler ones, null bit, then B9..B0
  function automatic logic resp_bit(input int k, input logic [23:0] fb);
    logic [9:0] v;
    v = adc_val[fb[14:12]];
    if (k < 13) return 1'b1;
    if (k == 13) return 1'b0;
    if (k < 24) return v[4'(23 - k)];
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_cs   = 1'b1;
      prev_sclk = 1'b0;
      bit_cnt   = 0;
      spi_miso  = 1'b0;
    end else begin
      if (sample_valid && sample_ready) sq.push_back({sample, sample_ch});
      if (scan_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_cs && !spi_cs) begin
        cs_fall_q.push_back(cyc);
        bit_cnt  = 0;
        fbits    = '0;
        spi_miso = resp_bit(0, '0);
      end else if (!spi_cs) begin
        if (spi_clk && !prev_sclk) begin
          if (bit_cnt < 24) fbits[5'(23 - bit_cnt)] = spi_mosi;
          bit_cnt++;
        end else if (!spi_clk && prev_sclk) begin
          spi_miso = resp_bit(bit_cnt, fbits);
        end
      end
      if (!prev_cs && spi_cs) frame_q.push_back(fbits);
      prev_cs   = spi_cs;
      prev_sclk = spi_clk;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_scan(input logic [7:0] m, input logic d, output int t_trig);
    sq.delete();
    frame_q.delete();
    cs_fall_q.delete();
    done0     = done_cnt;
    ch_mask   = m;
    diff_mode = d;
    @(posedge clk); #1 start_scan = 1'b1;
    @(negedge clk); t_trig = cyc;
    @(posedge clk); #1 start_scan = 1'b0;
  endtask

  task automatic wait_done(input int limit, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (done_cnt != done0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  mask;
    logic        diff;
    int          n;
    logic [7:0]  cmd_first;
    logic [7:0]  cmd_last;
    logic [12:0] first;
    logic [12:0] last;
  } vec_t;

  vec_t vt [0:5];

  initial begin
    int   t;
    logic ok;

    vt[0] = '{8'h05, 1'b0, 2, 8'h80, 8'hA0, {10'h155, 3'd0}, {10'h2AA, 3'd2}};
    vt[1] = '{8'h01, 1'b1, 1, 8'h00, 8'h00, {10'h155, 3'd0}, {10'h155, 3'd0}};
    vt[2] = '{8'h80, 1'b0, 1, 8'hF0, 8'hF0, {10'h312, 3'd7}, {10'h312, 3'd7}};
    vt[3] = '{8'hFF, 1'b0, 8, 8'h80, 8'hF0, {10'h155, 3'd0}, {10'h312, 3'd7}};
    vt[4] = '{8'h12, 1'b1, 2, 8'h10, 8'h40, {10'h0F0, 3'd1}, {10'h3FF, 3'd4}};
    vt[5] = '{8'h48, 1'b0, 2, 8'hB0, 8'hE0, {10'h001, 3'd3}, {10'h0AB, 3'd6}};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("rst_spi_cs", spi_cs, 1);
    chk("rst_spi_clk", spi_clk, 0);
    chk("rst_spi_mosi", spi_mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_sample", sample, 0);
    chk("rst_sample_ch", sample_ch, 0);
    chk("rst_scan_done", scan_done, 0);

`ifdef ADC_SCAN_TIMER_EN
    ch_mask = 8'h01;
    cs_fall_q.delete();
    for (int i = 0; i < 5000 && cs_fall_q.size() < 3; i++) step();
    chk("timer_scans", cs_fall_q.size(), 3);
    if (cs_fall_q.size() >= 3) begin
      chk("timer_gap1", cs_fall_q[1] - cs_fall_q[0], PERIOD);
      chk("timer_gap2", cs_fall_q[2] - cs_fall_q[1], PERIOD);
    end
    $display("timer scans at cycles: %0d entries", cs_fall_q.size());
`else
    for (int v = 0; v < 6; v++) begin
      do_scan(vt[v].mask, vt[v].diff, t);
      wait_done(3500, ok);
      chk("scan_done_seen", ok, 1);
      chk("n_samples", sq.size(), vt[v].n);
      chk("n_frames", frame_q.size(), vt[v].n);
      if (sq.size() > 0) begin
        chk("first_sample", sq[0], vt[v].first);
        chk("last_sample", sq[$], vt[v].last);
      end
      for (int i = 0; i < sq.size(); i++)
        chk("sample_data", sq[i][12:3], adc_val[sq[i][2:0]]);
      if (frame_q.size() > 0) begin
        chk("cmd_first", frame_q[0][15:8], vt[v].cmd_first);
        chk("cmd_last", frame_q[$][15:8], vt[v].cmd_last);
        chk("start_dummy", {frame_q[0][23:16], frame_q[0][7:0]}, 16'h0100);
      end
      if (cs_fall_q.size() > 0) begin
        chk("cs_latency", cs_fall_q[0] - t, 1);
        chk("scan_cycles", done_cyc - cs_fall_q[0], vt[v].n * FRAME);
      end
      $display("vec %0d mask=%02h diff=%0d samples=%0d frames=%0d cycles=%0d",
               v, vt[v].mask, vt[v].diff, sq.size(), frame_q.size(),
               (cs_fall_q.size() > 0) ? done_cyc - cs_fall_q[0] : 0);
    end

    // Empty mask: immediate scan_done, no frame
    do_scan(8'h00, 1'b0, t);
    wait_done(10, ok);
    chk("mask0_done", ok, 1);
    chk("mask0_latency", done_cyc - t, 1);
    chk("mask0_no_cs", cs_fall_q.size(), 0);
    chk("mask0_busy", busy, 0);
    $display("mask0 scan_done after %0d cycles", done_cyc - t);

    // Backpressure: second frame parks in STORE until the consumer returns
    @(posedge clk); #1 sample_ready = 1'b0;
    do_scan(8'h05, 1'b0, t);
    repeat (1000) step();
    chk("stall_busy", busy, 1);
    chk("stall_cs", spi_cs, 0);
    chk("stall_sclk", spi_clk, 0);
    chk("stall_valid", sample_valid, 1);
    chk("stall_sample", {sample, sample_ch}, {10'h155, 3'd0});
    chk("stall_frames", frame_q.size(), 1);
    chk("stall_no_done", done_cnt - done0, 0);
    @(posedge clk); #1 sample_ready = 1'b1;
    wait_done(1000, ok);
    chk("stall_done", ok, 1);
    chk("stall_n", sq.size(), 2);
    if (sq.size() >= 2) begin
      chk("stall_s0", sq[0], {10'h155, 3'd0});
      chk("stall_s1", sq[1], {10'h2AA, 3'd2});
    end
    $display("backpressure scan delivered %0d samples", sq.size());

    // Re-trigger while busy is dropped
    do_scan(8'h01, 1'b0, t);
    repeat (100) step();
    ch_mask = 8'hFF;
    @(posedge clk); #1 start_scan = 1'b1;
    @(posedge clk); #1 start_scan = 1'b0;
    wait_done(1000, ok);
    chk("retrig_done", ok, 1);
    repeat (400) step();
    chk("retrig_done_cnt", done_cnt - done0, 1);
    chk("retrig_samples", sq.size(), 1);
    chk("retrig_frames", frame_q.size(), 1);
    chk("retrig_idle", busy, 0);
    $display("retrigger scan produced %0d samples", sq.size());

    // Reset inside BYTE1 of the second frame with a sample still held
    @(posedge clk); #1 sample_ready = 1'b0;
    do_scan(8'h03, 1'b0, t);
    for (int i = 0; i < 1000 && cs_fall_q.size() < 2; i++) step();
    chk("rst_two_frames", cs_fall_q.size(), 2);
    repeat (200) step();
    chk("pre_rst_cs", spi_cs, 0);
    chk("pre_rst_valid", sample_valid, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    step();
    chk("mid_rst_cs", spi_cs, 1);
    chk("mid_rst_valid", sample_valid, 0);
    chk("mid_rst_busy", busy, 0);
    sample_ready = 1'b1;
    repeat (500) step();
    chk("mid_rst_no_done", done_cnt - done0, 0);
    chk("mid_rst_no_sample", sq.size(), 0);
    do_scan(8'h04, 1'b0, t);
    wait_done(1000, ok);
    chk("post_rst_done", ok, 1);
    chk("post_rst_n", sq.size(), 1);
    if (sq.size() > 0) chk("post_rst_sample", sq[0], {10'h2AA, 3'd2});
    if (frame_q.size() > 0) chk("post_rst_cmd", frame_q[0][15:8], 8'hA0);
    if (cs_fall_q.size() > 0) chk("post_rst_cycles", done_cyc - cs_fall_q[0], FRAME);
    $display("post-reset scan produced %0d samples", sq.size());
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
